cntr_param: RTL and testbench
=============================

# cntr_param

Parametrised up/down counter for the digital-lock datapath. It replaces the fixed 3-bit increment-only counter with:
- configurable width and modulus;
- wrap or saturate mode;
- synchronous clear and parallel load;
- terminal-count flags and one-cycle event pulses.

It serves as the digit-position, attempt and lockout-timer counter in the lock controller.

## Interface
Parameters:
- WIDTH, 3, counter width in bits; minimum 1.
- MODULUS, 8, count range is 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load of din.
- din  input  WIDTH  load value.
- inc  input  1  count up by one.
- dec  input  1  count down by one.
- dout  output  WIDTH  current count, registered.
- tc_max  output  1  high while dout == MODULUS-1 (decoded from register).
- tc_min  output  1  high while dout == 0 (decoded from register).
- wrap  output  1  one-cycle pulse: last update wrapped (wrap mode only).
- sat  output  1  one-cycle pulse: last update was blocked at a bound (saturate mode only).
- ld_err  output  1  one-cycle pulse: last load value was >= MODULUS.

## Operation
- Per-edge priority: rst_n low > clr > load > (inc XOR dec) > hold.
- clr: dout <= 0. No pulses are raised, and clr overrides load/inc/dec in the same cycle.
- load, din < MODULUS: dout <= din.
- load, din >= MODULUS: dout <= MODULUS-1 and ld_err pulses.
- inc and dec both high: no change, no pulses.
- inc only:
  - dout < MODULUS-1: dout+1.
  - At MODULUS-1 with SATURATE=0: dout <= 0 and wrap pulses.
  - At MODULUS-1 with SATURATE=1: dout holds and sat pulses.
- dec only:
  - dout > 0: dout-1.
  - At 0 with SATURATE=0: dout <= MODULUS-1 and wrap pulses.
  - At 0 with SATURATE=1: dout holds and sat pulses.
- Arithmetic is carried in WIDTH+1 bits internally so that MODULUS == 2**WIDTH never aliases. dout never leaves 0..MODULUS-1.
- wrap and sat are mutually exclusive by parameter. The unused one is tied 0.

## Timing
- All state updates occur on rising clk. dout, wrap, sat and ld_err are flops.
- Latency:
  - Control sampled at edge N is visible on dout after edge N.
  - Pulses are high for exactly the cycle following edge N.
  - tc_max and tc_min track dout with zero additional latency.
- Reset (rst_n low, asynchronous): dout=0, wrap=0, sat=0, ld_err=0. This gives tc_min=1, tc_max=0.
- Reset mid-operation: outputs clear immediately on the falling rst_n without waiting for clk. A pulse in flight is dropped.
- Reset release: the first counting edge is the first rising clk with rst_n high.
- Back-to-back inc at the bound in wrap mode produces a wrap pulse only on the wrapping edge, not on the following increment.
- Holding inc high in saturate mode at the bound re-asserts sat every cycle.

## Structure
- Shared package/include cntr_defs: mode constants CNTR_WRAP=0 and CNTR_SAT=1, plus a width-check macro. The lock controller and this block use the same constants.
- One sub-module: cntr_step, a combinational next-value unit. Inputs: dout, inc, dec, and parameters. Outputs: next count, wrap_evt, sat_evt.
- cntr_param owns the priority mux (clr/load/step), the load clamp, the flops and the tc decode.
- Elaboration check: MODULUS outside 2..2**WIDTH is a compile-time error.

## Test plan
All scenarios use WIDTH=3, MODULUS=6 unless noted.
- Reset: assert rst_n low mid-count at dout=4, between clock edges. dout=0 and tc_min=1 immediately, and all pulses are 0.
- Wrap, SATURATE=0:
  - Load 5 then inc. dout=0 and wrap=1 for one cycle.
  - dec at 0 gives dout=5 and wrap=1.
- Saturate, SATURATE=1: load 5, then hold inc for 3 cycles. dout stays 5, and sat=1 for all 3 cycles.
- Priority:
  - clr+load+inc in the same cycle with din=3 gives dout=0.
  - load+inc with din=2 gives dout=2.
  - inc+dec at dout=3 gives dout=3 with no pulses.
- Load clamp: load din=7. dout=5, ld_err=1 for one cycle, tc_max=1.
- Full range, WIDTH=3, MODULUS=8: 8 incs from 0 return dout to 0 with a single wrap pulse, and 9 decs from 0 end at dout=7.

Source files
------------

// File: rtl/cntr_defs_pkg.sv
// Shared counter definitions: mode constants and modulus sanity checks used by
// the lock controller and the parametrised counter.
`ifndef CNTR_DEFS_SVH
`define CNTR_DEFS_SVH
`define CNTR_WIDTH_OK(w, m) (((m) >= 2) && ((m) <= (1 << (w))))
`endif

package cntr_defs;

    localparam int CNTR_WRAP = 0;
    localparam int CNTR_SAT  = 1;

    // Evaluated in 64 bits so wide counters do not overflow the shift.
    function automatic bit cntr_modulus_ok(input int width, input int modulus);
        longint unsigned span;
        span = longint'(1) << width;
        return (width >= 1) && (modulus >= 2) && (longint'(modulus) <= span);
    endfunction

endpackage

// File: rtl/cntr_param_step.sv
// Combinational next-value unit: applies one inc or dec step to the current
// count and reports whether the step wrapped or was blocked at a bound.
module cntr_step
    import cntr_defs::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = CNTR_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] next,
    output logic             wrap_evt,
    output logic             sat_evt
);

    localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] cur;

    // Bound tests are done one bit wider so a full-range modulus cannot alias.
    always_comb begin
        cur      = {1'b0, count};
        next     = count;
        wrap_evt = 1'b0;
        sat_evt  = 1'b0;
        if (inc && !dec) begin
            if (cur < TOP_EXT) begin
                next = count + 1'b1;
            end else if (SATURATE == CNTR_SAT) begin
                sat_evt = 1'b1;
            end else begin
                next     = '0;
                wrap_evt = 1'b1;
            end
        end else if (dec && !inc) begin
            if (cur != '0) begin
                next = count - 1'b1;
            end else if (SATURATE == CNTR_SAT) begin
                sat_evt = 1'b1;
            end else begin
                next     = MAX_VAL;
                wrap_evt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cntr_param.sv
// Parametrised up/down counter with clear, clamped load, wrap/saturate modes,
// terminal-count decode and one-cycle event pulses.
module cntr_param
    import cntr_defs::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = CNTR_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] dout,
    output logic             tc_max,
    output logic             tc_min,
    output logic             wrap,
    output logic             sat,
    output logic             ld_err
);

    generate
        if (!cntr_modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
            $error("cntr_param: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] step_next;
    logic             step_wrap;
    logic             step_sat;
    logic [WIDTH-1:0] nxt_dout;
    logic             nxt_wrap;
    logic             nxt_sat;
    logic             nxt_lderr;
    logic             over;

    cntr_step #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_step (
        .count    (dout),
        .inc      (inc),
        .dec      (dec),
        .next     (step_next),
        .wrap_evt (step_wrap),
        .sat_evt  (step_sat)
    );

    // Priority: clr, then load (clamped to the top of range), then the step unit.
    always_comb begin
        nxt_dout  = dout;
        nxt_wrap  = 1'b0;
        nxt_sat   = 1'b0;
        nxt_lderr = 1'b0;
        over      = ({1'b0, din} >= MOD_EXT);
        if (clr) begin
            nxt_dout = '0;
        end else if (load) begin
            if (over) begin
                nxt_dout  = MAX_VAL;
                nxt_lderr = 1'b1;
            end else begin
                nxt_dout = din;
            end
        end else begin
            nxt_dout = step_next;
            nxt_wrap = step_wrap;
            nxt_sat  = step_sat;
        end
    end

    // The pulse belonging to the other mode is forced low so it folds to a constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            wrap   <= 1'b0;
            sat    <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            dout   <= nxt_dout;
            wrap   <= (SATURATE == CNTR_WRAP) && nxt_wrap;
            sat    <= (SATURATE == CNTR_SAT) && nxt_sat;
            ld_err <= nxt_lderr;
        end
    end

    assign tc_max = (dout == MAX_VAL);
    assign tc_min = (dout == '0);

endmodule

// File: tb/tb_cntr_param.sv
// Bench for cntr_param: three instances (mod-6 wrap, mod-6 saturate, mod-8 wrap)
// share one stimulus stream and are checked against an arithmetic model.
module tb_cntr_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       load;
    logic [2:0] din;
    logic       inc;
    logic       dec;

    logic [2:0] dout   [3];
    logic       tc_max [3];
    logic       tc_min [3];
    logic       wrap   [3];
    logic       sat    [3];
    logic       ld_err [3];

    int errors = 0;
    int checks = 0;

    int mmod  [3] = '{6, 6, 8};
    bit msat  [3] = '{1'b0, 1'b1, 1'b0};
    int mcnt  [3];
    bit mwrap [3];
    bit msatp [3];
    bit mlerr [3];

    always #5 clk = ~clk;

    cntr_param #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_wrap6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .din(din), .inc(inc), .dec(dec),
        .dout(dout[0]), .tc_max(tc_max[0]), .tc_min(tc_min[0]),
        .wrap(wrap[0]), .sat(sat[0]), .ld_err(ld_err[0]));

    cntr_param #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u_sat6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .din(din), .inc(inc), .dec(dec),
        .dout(dout[1]), .tc_max(tc_max[1]), .tc_min(tc_min[1]),
        .wrap(wrap[1]), .sat(sat[1]), .ld_err(ld_err[1]));

    cntr_param #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_wrap8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .din(din), .inc(inc), .dec(dec),
        .dout(dout[2]), .tc_max(tc_max[2]), .tc_min(tc_min[2]),
        .wrap(wrap[2]), .sat(sat[2]), .ld_err(ld_err[2]));

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; mwrap[k] = 0; msatp[k] = 0; mlerr[k] = 0;
        end
    endfunction

    // Counting on the integer line, then folding back into 0..mod-1.
    function automatic void model_apply(bit c, bit l, int d, bit i, bit de);
        int n;
        for (int k = 0; k < 3; k++) begin
            mwrap[k] = 0; msatp[k] = 0; mlerr[k] = 0;
            if (c) begin
                mcnt[k] = 0;
            end else if (l) begin
                if (d >= mmod[k]) begin
                    mcnt[k] = mmod[k] - 1;
                    mlerr[k] = 1;
                end else begin
                    mcnt[k] = d;
                end
            end else if (i != de) begin
                n = mcnt[k] + (i ? 1 : -1);
                if (n < 0 || n >= mmod[k]) begin
                    if (msat[k]) msatp[k] = 1;
                    else begin
                        mwrap[k] = 1;
                        mcnt[k] = (n + mmod[k]) % mmod[k];
                    end
                end else begin
                    mcnt[k] = n;
                end
            end
        end
    endfunction

    task automatic apply_cycle(input bit c, input bit l, input logic [2:0] d,
                               input bit i, input bit de);
        clr = c; load = l; din = d; inc = i; dec = de;
        @(posedge clk);
        #1;
        model_apply(c, l, int'(d), i, de);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 0; load = 0; din = 0; inc = 0; dec = 0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({dout[k], tc_max[k], tc_min[k], wrap[k], sat[k], ld_err[k]} !== {3'd0, 5'b01000}) begin
                errors++;
                $display("[TB] FAIL reset_state[%0d]: got %b want %b", k,
                         {dout[k], tc_max[k], tc_min[k], wrap[k], sat[k], ld_err[k]}, {3'd0, 5'b01000});
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply_cycle(0, 1, 3'd4, 0, 0);
        checks++;
        if (dout[0] !== 3'd4) begin
            errors++;
            $display("[TB] FAIL reset_preload: got %0d want 4", dout[0]);
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({dout[k], tc_min[k], wrap[k], sat[k], ld_err[k]} !== {3'd0, 4'b1000}) begin
                errors++;
                $display("[TB] FAIL reset_async[%0d]: got %b want %b", k,
                         {dout[k], tc_min[k], wrap[k], sat[k], ld_err[k]}, {3'd0, 4'b1000});
            end
        end
        #2 rst_n = 1'b1;
        apply_cycle(0, 1, 3'd7, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({ld_err[0], ld_err[1], dout[0]} !== {2'b00, 3'd0}) begin
            errors++;
            $display("[TB] FAIL reset_drop_pulse: got %b want 00000", {ld_err[0], ld_err[1], dout[0]});
        end
        #2 rst_n = 1'b1;
        apply_cycle(0, 0, 3'd0, 1, 0);
        checks++;
        if (dout[0] !== 3'd1) begin
            errors++;
            $display("[TB] FAIL reset_first_edge: got %0d want 1", dout[0]);
        end
    endtask

    task automatic test_wrap();
        apply_cycle(0, 1, 3'd5, 0, 0);
        apply_cycle(0, 0, 3'd0, 1, 0);
        checks++;
        if ({dout[0], wrap[0], sat[0]} !== {3'd0, 2'b10}) begin
            errors++;
            $display("[TB] FAIL wrap_inc: got %b want %b", {dout[0], wrap[0], sat[0]}, {3'd0, 2'b10});
        end
        apply_cycle(0, 0, 3'd0, 0, 0);
        checks++;
        if (wrap[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_one_cycle: got %b want 0", wrap[0]);
        end
        apply_cycle(0, 0, 3'd0, 0, 1);
        checks++;
        if ({dout[0], wrap[0], tc_max[0]} !== {3'd5, 2'b11}) begin
            errors++;
            $display("[TB] FAIL wrap_dec: got %b want %b", {dout[0], wrap[0], tc_max[0]}, {3'd5, 2'b11});
        end
        apply_cycle(0, 1, 3'd4, 0, 0);
        apply_cycle(0, 0, 3'd0, 1, 0);
        apply_cycle(0, 0, 3'd0, 1, 0);
        checks++;
        if ({dout[0], wrap[0]} !== {3'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL b2b_wrap_edge: got %b want %b", {dout[0], wrap[0]}, {3'd0, 1'b1});
        end
        apply_cycle(0, 0, 3'd0, 1, 0);
        checks++;
        if ({dout[0], wrap[0]} !== {3'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_after_wrap: got %b want %b", {dout[0], wrap[0]}, {3'd1, 1'b0});
        end
    endtask

    task automatic test_saturate();
        apply_cycle(0, 1, 3'd5, 0, 0);
        for (int n = 0; n < 3; n++) begin
            apply_cycle(0, 0, 3'd0, 1, 0);
            checks++;
            if ({dout[1], sat[1], wrap[1]} !== {3'd5, 2'b10}) begin
                errors++;
                $display("[TB] FAIL sat_hold_inc[%0d]: got %b want %b", n,
                         {dout[1], sat[1], wrap[1]}, {3'd5, 2'b10});
            end
        end
        apply_cycle(1, 0, 3'd0, 0, 0);
        apply_cycle(0, 0, 3'd0, 0, 1);
        checks++;
        if ({dout[1], sat[1], tc_min[1]} !== {3'd0, 2'b11}) begin
            errors++;
            $display("[TB] FAIL sat_dec_floor: got %b want %b", {dout[1], sat[1], tc_min[1]}, {3'd0, 2'b11});
        end
    endtask

    task automatic test_priority();
        apply_cycle(0, 1, 3'd4, 0, 0);
        apply_cycle(1, 1, 3'd3, 1, 0);
        checks++;
        if ({dout[0], dout[1], dout[2]} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL prio_clr: got %b want 0", {dout[0], dout[1], dout[2]});
        end
        apply_cycle(0, 1, 3'd2, 1, 0);
        checks++;
        if (dout[0] !== 3'd2) begin
            errors++;
            $display("[TB] FAIL prio_load_over_inc: got %0d want 2", dout[0]);
        end
        apply_cycle(0, 1, 3'd3, 0, 0);
        apply_cycle(0, 0, 3'd0, 1, 1);
        checks++;
        if ({dout[0], wrap[0], sat[1], ld_err[0]} !== {3'd3, 3'b000}) begin
            errors++;
            $display("[TB] FAIL prio_inc_dec: got %b want %b", {dout[0], wrap[0], sat[1], ld_err[0]}, {3'd3, 3'b000});
        end
    endtask

    task automatic test_clamp();
        apply_cycle(0, 1, 3'd7, 0, 0);
        checks++;
        if ({dout[0], ld_err[0], tc_max[0]} !== {3'd5, 2'b11}) begin
            errors++;
            $display("[TB] FAIL clamp_mod6: got %b want %b", {dout[0], ld_err[0], tc_max[0]}, {3'd5, 2'b11});
        end
        checks++;
        if ({dout[2], ld_err[2], tc_max[2]} !== {3'd7, 2'b01}) begin
            errors++;
            $display("[TB] FAIL clamp_mod8_inrange: got %b want %b", {dout[2], ld_err[2], tc_max[2]}, {3'd7, 2'b01});
        end
        apply_cycle(0, 0, 3'd0, 0, 0);
        checks++;
        if (ld_err[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp_pulse_len: got %b want 0", ld_err[0]);
        end
    endtask

    task automatic test_full_range();
        int wraps;
        apply_cycle(1, 0, 3'd0, 0, 0);
        wraps = 0;
        for (int n = 0; n < 8; n++) begin
            apply_cycle(0, 0, 3'd0, 1, 0);
            if (wrap[2] === 1'b1) wraps++;
        end
        checks++;
        if ({dout[2], 4'(wraps)} !== {3'd0, 4'd1}) begin
            errors++;
            $display("[TB] FAIL full_range_inc: got dout=%0d wraps=%0d want dout=0 wraps=1", dout[2], wraps);
        end
        apply_cycle(1, 0, 3'd0, 0, 0);
        for (int n = 0; n < 9; n++) apply_cycle(0, 0, 3'd0, 0, 1);
        checks++;
        if (dout[2] !== 3'd7) begin
            errors++;
            $display("[TB] FAIL full_range_dec: got %0d want 7", dout[2]);
        end
    endtask

    task automatic test_random();
        logic [2:0] exp_cnt;
        logic [4:0] exp_flags;
        for (int n = 0; n < 400; n++) begin
            apply_cycle(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                        3'($urandom_range(7)), 1'($urandom), 1'($urandom));
            for (int k = 0; k < 3; k++) begin
                exp_cnt   = 3'(mcnt[k]);
                exp_flags = {(mcnt[k] == mmod[k] - 1), (mcnt[k] == 0), mwrap[k], msatp[k], mlerr[k]};
                checks++;
                if ({dout[k], tc_max[k], tc_min[k], wrap[k], sat[k], ld_err[k]} !== {exp_cnt, exp_flags}) begin
                    errors++;
                    $display("[TB] FAIL random[%0d] inst %0d: got %b want %b", n, k,
                             {dout[k], tc_max[k], tc_min[k], wrap[k], sat[k], ld_err[k]}, {exp_cnt, exp_flags});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_priority();
        test_clamp();
        test_full_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
